// File: rtl/stream_demux_1xn.sv
// ============================================================================
// stream_demux_1xn
// ----------------------------------------------------------------------------
// Registered 1-to-N stream demultiplexer with valid/ready handshakes on the
// input and on every output channel. Each accepted input beat is steered to
// the channel named by the effective select and parked in that channel's
// one-entry output register until the consumer takes it. Beats whose select
// names a channel that does not exist are discarded and counted.
//
// Optional build feature (macro STREAM_DEMUX_PKT_LOCK_EN):
//   When defined, the select of a packet's first beat is latched and used
//   for every following beat up to and including the one with in_last=1, so
//   a packet can never be split across channels. When undefined, every beat
//   follows its own in_sel and in_last is only carried to the output.
//
// Parameters:
//   N_CH  number of output channels (2..16)
//   DW    payload width in bits
//   SW    select width, $clog2(N_CH) by default
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  input beat can be accepted (depends on target channel only)
//   in_data    in   [DW]        input payload
//   in_sel     in   [SW]        destination channel
//   in_last    in   last beat of a packet
//   out_valid  out  [N_CH]      per-channel valid, bit i is channel i
//   out_ready  in   [N_CH]      per-channel ready
//   out_data   out  [N_CH*DW]   channel i at bits [i*DW +: DW]
//   out_last   out  [N_CH]      per-channel last flag
//   drop_err   out  one-cycle pulse the cycle after a beat is dropped
//   drop_cnt   out  [8]         saturating count of dropped beats
// ============================================================================
module stream_demux_1xn #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    parameter int SW   = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    input  logic [SW-1:0]        in_sel,
    input  logic                 in_last,
    output logic [N_CH-1:0]      out_valid,
    input  logic [N_CH-1:0]      out_ready,
    output logic [N_CH*DW-1:0]   out_data,
    output logic [N_CH-1:0]      out_last,
    output logic                 drop_err,
    output logic [7:0]           drop_cnt
);

    // ------------------------------------------------------------------------
    // Effective select
    // ------------------------------------------------------------------------
    logic [SW-1:0] esel;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    lock_state_e   state_q, state_d;
    logic [SW-1:0] lock_sel_q;
`endif

    // One-hot decode of the effective select. A select beyond the last
    // channel decodes to all zeros, which is what marks a beat for dropping.
    logic [N_CH-1:0] hit;
    logic            in_range;
    logic            accept;
    logic            drop;
    logic [N_CH-1:0] load;

    // Per-channel holding registers; out_data is just the packed view.
    logic [N_CH-1:0][DW-1:0] data_q;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
    // Mid-packet the latched select wins and in_sel is ignored.
    assign esel = (state_q == ST_LOCKED) ? lock_sel_q : in_sel;
`else
    assign esel = in_sel;
`endif

    // NOTE: every signal written in an always_comb gets a default first so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            hit[i] = (32'(esel) == 32'(i));
        end
    end

    assign in_range = |hit;

    // Ready looks only at the targeted channel: it is blocked only when that
    // channel is full and its consumer is not taking the beat this cycle.
    // Out-of-range selects hit no channel and are always ready (to drop).
    assign in_ready = ~|(hit & out_valid & ~out_ready);

    assign accept = in_valid & in_ready;
    assign load   = {N_CH{accept}} & hit;
    assign drop   = accept & ~in_range;

    // ------------------------------------------------------------------------
    // Channel registers
    // ------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples the values from before the edge, independent of the
    // order in which the simulator evaluates processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_last  <= '0;
            // NOTE: the payload registers are reset as well even though valid
            // alone would qualify them; the outputs must read 0 after reset
            // and no stale payload may survive a reset.
            data_q    <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (load[i]) begin
                    // Covers both a fresh load and drain+reload in one cycle:
                    // the new beat replaces the old and valid stays high.
                    out_valid[i] <= 1'b1;
                    out_last[i]  <= in_last;
                    data_q[i]    <= in_data;
                end else if (out_ready[i]) begin
                    // Drained (or idle): valid clears, payload holds.
                    out_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign out_data = data_q;

    // ------------------------------------------------------------------------
    // Drop reporting
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err <= 1'b0;
            drop_cnt <= '0;
        end else begin
            drop_err <= drop;
            if (drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

`ifdef STREAM_DEMUX_PKT_LOCK_EN
    // ------------------------------------------------------------------------
    // Packet lock FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lock_sel_q <= '0;
        end else begin
            state_q <= state_d;
            // The first beat of a multi-beat packet fixes the route, even if
            // it is out of range: the whole packet is then dropped.
            if ((state_q == ST_IDLE) && accept && !in_last) begin
                lock_sel_q <= in_sel;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A single-beat packet (last on the first beat) never locks.
                if (accept && !in_last) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (accept && in_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
`endif

endmodule

// File: doc/stream_demux_1xn.md
# stream_demux_1xn

Registered 1-to-N stream demultiplexer with valid/ready flow control on the input and on every output channel. Each accepted input beat is routed to the channel chosen by `in_sel` and held in that channel's one-entry output register until the downstream consumer takes it. It sits between a single producer and N independent consumers, and replaces the combinational 1x4 demux wherever back-pressure, wider data or more channels are needed.

## Interface
Parameters:
- `N_CH`, default 4: number of output channels, 2..16.
- `DW`, default 8: data width in bits.
- `SW`, default `$clog2(N_CH)`: select width.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `in_valid` input 1: input beat valid.
- `in_ready` output 1: block can accept an input beat.
- `in_data` input DW: input payload.
- `in_sel` input SW: destination channel.
- `in_last` input 1: last beat of a packet.
- `out_valid` output N_CH: per-channel valid, bit i is channel i.
- `out_ready` input N_CH: per-channel ready.
- `out_data` output N_CH*DW: channel i occupies bits [i*DW +: DW].
- `out_last` output N_CH: per-channel last flag.
- `drop_err` output 1: one-cycle pulse when a beat is dropped.
- `drop_cnt` output 8: saturating count of dropped beats.

## Operation
- Beat accepted when `in_valid && in_ready`. Output channel i transfers when `out_valid[i] && out_ready[i]`.
- Effective select `esel` is `in_sel`, or the locked select when packet lock is enabled (see Configuration).
- `in_ready` = 1 if `esel >= N_CH`; otherwise `!out_valid[esel] || out_ready[esel]`. It depends only on the target channel, so a full channel never stalls on another channel's state.
- Accepted beat with `esel < N_CH` loads `out_data`, `out_last` and sets `out_valid` of channel `esel`. Every other channel holds its data, last and valid unchanged.
- Channel i drained without a reload: `out_valid[i]` clears, and `out_data[i]` and `out_last[i]` hold their last values.
- Simultaneous drain and reload on the same channel: the new beat replaces the old one and `out_valid` stays 1, giving full throughput of one beat per cycle per channel.
- Accepted beat with `esel >= N_CH` (only possible when N_CH is not a power of 2): beat is discarded, `drop_err` pulses for 1 cycle, `drop_cnt` increments and saturates at 255.
- `out_valid[i]` never deasserts without a transfer, and `out_data[i]` is stable while `out_valid[i] && !out_ready[i]`.
- Reset values: `out_valid`=0, `out_data`=0, `out_last`=0, `drop_err`=0, `drop_cnt`=0, lock state IDLE.
- Reset asserted mid-packet: all buffered beats are lost and lock returns to IDLE. No partial state survives reset.

## Timing
- Latency: 1 cycle, from input acceptance at edge k to `out_valid` high after edge k.
- `in_ready` is combinational from `in_sel`, `in_last` state, `out_valid` and `out_ready`. There is no combinational path from `in_data` to any output.
- `drop_err` is registered and asserts the cycle after the dropping acceptance.
- Throughput: 1 beat/cycle aggregate, provided the target channel is ready.

## Configuration
- Macro: `STREAM_DEMUX_PKT_LOCK_EN`.
- Defined: two-state FSM, IDLE and LOCKED.
  - In IDLE, `esel` = `in_sel`. An accepted beat with `in_last`=0 captures `in_sel` into `lock_sel` and moves to LOCKED.
  - In LOCKED, `esel` = `lock_sel` and `in_sel` is ignored. An accepted beat with `in_last`=1 returns to IDLE.
  - A single-beat packet (`in_last`=1 in IDLE) stays in IDLE.
  - If the packet's first beat has an out-of-range select, every beat of that packet is dropped and counted.
- Undefined: no FSM. `esel` = `in_sel` on every beat, and `in_last` is passed through only.

## Test plan
- Reset with `N_CH`=4, `DW`=8: all outputs 0. Send 0xA5 to sel 2 with all ready=1 -> `out_valid`=4'b0100 and `out_data[23:16]`=0xA5 one cycle later. Other channels' data stays 0.
- Back-pressure: `out_ready[1]`=0, send 0x11 then 0x22 to sel 1 -> 0x11 is held, `in_ready`=0 while the second beat waits. Meanwhile a beat to sel 3 is accepted at once. Raise `out_ready[1]` -> 0x22 lands the next cycle.
- Streaming: `out_ready[0]`=1, back-to-back beats 0..15 to sel 0 -> `in_ready` stays 1 and channel 0 emits 0..15 on consecutive cycles.
- `N_CH`=5, sel 7 for 300 beats -> `in_ready`=1, no `out_valid`, `drop_err` pulses 300 times, `drop_cnt` saturates at 255.
- With `STREAM_DEMUX_PKT_LOCK_EN`: 3-beat packet, first beat sel 1, then sel 3 and sel 0 with `last` on beat 3 -> all three beats on channel 1. The next packet with sel 3 goes to channel 3.
- Assert `rst_n` low mid-packet with channels full -> all `out_valid` drop asynchronously. After release, the first beat follows its own `in_sel`.
